// File: rtl/output_deskew.sv
// -----------------------------------------------------------------------------
// output_deskew
//
// Collects skewed per-column results from the systolic array and re-aligns
// them into whole rows. One N x N result matrix is buffered. Each column
// fills its own buffer column in arrival order. A row is presented downstream
// once every column has delivered its element for that row. Rows leave in
// order 0..N-1 through a valid/ready handshake.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   reset      : synchronous, active-high; clears all state
//   col_data   : per-column result, column j at [j*DATA_W +: DATA_W]
//   col_valid  : col_valid[j]=1 -> col_data column j is that column's next row
//   out_data   : aligned row, element j at [j*DATA_W +: DATA_W] (registered)
//   out_row    : index of the row on out_data (registered)
//   out_valid  : out_data/out_row hold a complete row
//   out_ready  : downstream accepts the row when out_valid & out_ready
//   done       : one-cycle pulse after row N-1 has transferred
//   overflow   : sticky; a column delivered data while its buffer column was
//                full. Cleared only by reset.
// -----------------------------------------------------------------------------
module output_deskew #(
    parameter int N      = 2,
    parameter int DATA_W = 32,
    localparam int ROW_W = (N > 1) ? $clog2(N) : 1,
    localparam int WC_W  = $clog2(N + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N*DATA_W-1:0] col_data,
    input  logic [N-1:0]        col_valid,
    output logic [N*DATA_W-1:0] out_data,
    output logic [ROW_W-1:0]    out_row,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                done,
    output logic                overflow
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_PRESENT
    } state_t;

    state_t                state_reg;
    state_t                state_next;
    logic [ROW_W-1:0]      rp_reg;
    logic [ROW_W-1:0]      rp_next;
    logic [N*DATA_W-1:0]   out_data_reg;
    logic [N*DATA_W-1:0]   out_data_next;
    logic [ROW_W-1:0]      out_row_reg;
    logic                  done_reg;
    logic                  overflow_reg;

    logic                  handshake;
    logic                  last_handshake;
    logic                  load_row;
    logic                  row_complete;
    logic                  any_pending;

    // Per-column status, produced inside the column generate blocks.
    logic [N-1:0]          col_has_row;   // column already holds row rp_next
    logic [N-1:0]          col_nonzero;   // column holds any element after this edge
    logic [N-1:0]          col_overflow;  // column dropped data this cycle

    assign handshake      = (state_reg == ST_PRESENT) && out_ready;
    assign last_handshake = handshake && (rp_reg == ROW_W'(N - 1));

    // Read pointer: advance on each accepted row, wrap to 0 after row N-1.
    always_comb begin
        rp_next = rp_reg;
        if (last_handshake) begin
            rp_next = '0;
        end else if (handshake) begin
            rp_next = rp_reg + ROW_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Per-column storage and write counter.
    //
    // Completion is judged on the post-edge counters, and the row loaded into
    // out_data bypasses the memory for elements written in this very cycle.
    // That gives one clock from the last contributing write to out_valid, and
    // lets the next row follow a handshake without a bubble.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_col
            logic [WC_W-1:0]   wc_reg;
            logic [WC_W-1:0]   wc_next;
            logic [DATA_W-1:0] col_mem [N];
            logic              has_space;
            logic              wr_en;
            logic [ROW_W-1:0]  wr_row;
            logic [DATA_W-1:0] wr_data;
            logic [DATA_W-1:0] row_elem;

            assign wr_data   = col_data[gi*DATA_W +: DATA_W];
            assign has_space = (wc_reg < WC_W'(N));

            // The row N-1 handshake empties the buffer in the same edge, so a
            // write arriving then becomes row 0 of the next matrix.
            assign wr_en  = col_valid[gi] && (last_handshake || has_space);
            assign wr_row = last_handshake ? '0 : wc_reg[ROW_W-1:0];

            assign col_overflow[gi] = col_valid[gi] && !last_handshake && !has_space;

            always_comb begin
                wc_next = wc_reg;
                if (last_handshake) begin
                    wc_next = WC_W'(col_valid[gi]);
                end else if (wr_en) begin
                    wc_next = wc_reg + WC_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    wc_reg <= '0;
                end else begin
                    wc_reg <= wc_next;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int r = 0; r < N; r++) begin
                        col_mem[r] <= '0;
                    end
                end else if (wr_en) begin
                    col_mem[wr_row] <= wr_data;
                end
            end

            // Element of row rp_next as it will exist after this edge.
            assign row_elem = (wr_en && (wr_row == rp_next)) ? wr_data
                                                             : col_mem[rp_next];

            assign out_data_next[gi*DATA_W +: DATA_W] = row_elem;
            assign col_has_row[gi] = (wc_next > WC_W'(rp_next));
            assign col_nonzero[gi] = (wc_next != '0);
        end
    endgenerate

    assign row_complete = &col_has_row;
    assign any_pending  = |col_nonzero;

    // -------------------------------------------------------------------------
    // Control FSM: next state and row-load decision.
    // A stalled PRESENT holds everything; otherwise the next state follows
    // from whether row rp_next is complete once this edge's writes land.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        load_row   = 1'b0;
        case (state_reg)
            ST_PRESENT: begin
                if (!out_ready) begin
                    state_next = ST_PRESENT;
                end else if (row_complete) begin
                    state_next = ST_PRESENT;
                    load_row   = 1'b1;
                end else if (any_pending) begin
                    state_next = ST_COLLECT;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE, ST_COLLECT: begin
                if (row_complete) begin
                    state_next = ST_PRESENT;
                    load_row   = 1'b1;
                end else if (any_pending) begin
                    state_next = ST_COLLECT;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            rp_reg       <= '0;
            out_data_reg <= '0;
            out_row_reg  <= '0;
            done_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            rp_reg    <= rp_next;
            if (load_row) begin
                out_data_reg <= out_data_next;
                out_row_reg  <= rp_next;
            end
            done_reg     <= last_handshake;
            overflow_reg <= overflow_reg | (|col_overflow);
        end
    end

    assign out_data  = out_data_reg;
    assign out_row   = out_row_reg;
    assign out_valid = (state_reg == ST_PRESENT);
    assign done      = done_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_output_deskew.sv
// -----------------------------------------------------------------------------
// tb_output_deskew
//
// Directed bench for output_deskew (N=2, DATA_W=32). Stimulus pushes the
// expected rows into a scoreboard queue; a monitor pops and compares on every
// out_valid & out_ready transfer. Cycle-specific behaviour (latency, hold
// under backpressure, done, overflow, reset) is checked inline.
// -----------------------------------------------------------------------------
module tb_output_deskew;

    localparam int N      = 2;
    localparam int DATA_W = 32;

    logic                clk = 1'b0;
    logic                reset;
    logic [N*DATA_W-1:0] col_data;
    logic [N-1:0]        col_valid;
    logic [N*DATA_W-1:0] out_data;
    logic [0:0]          out_row;
    logic                out_valid;
    logic                out_ready;
    logic                done;
    logic                overflow;

    always #5 clk = ~clk;

    output_deskew #(.N(N), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .col_data  (col_data),
        .col_valid (col_valid),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .done      (done),
        .overflow  (overflow)
    );

    typedef struct packed {
        logic        row;
        logic [63:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic row, input logic [31:0] d1, input logic [31:0] d0);
        sb_q.push_back({row, d1, d0});
    endtask

    // One cycle of stimulus; returns at the following falling edge so the
    // caller can inspect outputs for that cycle.
    task automatic cyc(input logic [1:0] v, input logic [31:0] d0,
                       input logic [31:0] d1, input logic rdy);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        col_valid = v;
        col_data  = {d1, d0};
        out_ready = rdy;
        @(negedge clk);
    endtask

    task automatic rst_cyc();
        @(posedge clk);
        #1;
        reset     = 1'b1;
        col_valid = '0;
        col_data  = '0;
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) begin
            cyc(2'b00, 0, 0, rdy);
        end
    endtask

    // Scoreboard monitor: one line per transferred row.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL row_xfer: got row %0d data %h, expected no transfer",
                         out_row, out_data);
            end else begin
                mon_e = sb_q.pop_front();
                if ({out_row, out_data} !== {mon_e.row, mon_e.data}) begin
                    n_bad++;
                    $display("FAIL row_xfer: got row %0d data %h, expected row %0d data %h",
                             out_row, out_data, mon_e.row, mon_e.data);
                end else begin
                    $display("xfer row %0d data %h", out_row, out_data);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected normal end");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        col_valid = '0;
        col_data  = '0;
        out_ready = 1'b0;

        rst_cyc();
        rst_cyc();
        cyc(2'b00, 0, 0, 0);
        chk("rst_valid",    64'(out_valid), 64'd0);
        chk("rst_done",     64'(done),      64'd0);
        chk("rst_overflow", 64'(overflow),  64'd0);
        chk("rst_data",     out_data,       64'd0);
        chk("rst_row",      64'(out_row),   64'd0);

        // --- 1: skewed feed, always ready ---
        push(1'b0, 20, 10);
        push(1'b1, 40, 30);
        cyc(2'b01, 10, 0, 1);  chk("a_t0_valid", 64'(out_valid), 64'd0);
        cyc(2'b11, 30, 20, 1); chk("a_t1_valid", 64'(out_valid), 64'd0);
        cyc(2'b10, 0, 40, 1);  chk("a_t2_valid", 64'(out_valid), 64'd1);
                               chk("a_t2_row",   64'(out_row),   64'd0);
        cyc(2'b00, 0, 0, 1);   chk("a_t3_valid", 64'(out_valid), 64'd1);
                               chk("a_t3_data",  out_data, {32'd40, 32'd30});
        cyc(2'b00, 0, 0, 1);   chk("a_t4_done",  64'(done),      64'd1);
                               chk("a_t4_valid", 64'(out_valid), 64'd0);
        cyc(2'b00, 0, 0, 1);   chk("a_t5_done",  64'(done),      64'd0);

        // --- 2: same feed, ready held low until t6 ---
        push(1'b0, 20, 10);
        push(1'b1, 40, 30);
        cyc(2'b01, 10, 0, 0);
        cyc(2'b11, 30, 20, 0);
        cyc(2'b10, 0, 40, 0);  chk("b_t2_hold", out_data, {32'd20, 32'd10});
        for (int t = 3; t <= 5; t++) begin
            cyc(2'b00, 0, 0, 0);
            chk("b_hold_data",  out_data, {32'd20, 32'd10});
            chk("b_hold_valid", 64'(out_valid), 64'd1);
            chk("b_hold_row",   64'(out_row),   64'd0);
        end
        cyc(2'b00, 0, 0, 1);   chk("b_t6_data",  out_data, {32'd20, 32'd10});
        cyc(2'b00, 0, 0, 1);   chk("b_t7_row",   64'(out_row),   64'd1);
                               chk("b_t7_valid", 64'(out_valid), 64'd1);
        cyc(2'b00, 0, 0, 1);   chk("b_t8_done",  64'(done),      64'd1);
        idle(2, 1);

        // --- 3: columns far apart ---
        push(1'b0, 21, 11);
        push(1'b1, 22, 12);
        cyc(2'b01, 11, 0, 1);
        cyc(2'b01, 12, 0, 1);
        idle(3, 1);
        cyc(2'b10, 0, 21, 1);  chk("c_t5_valid", 64'(out_valid), 64'd0);
        cyc(2'b10, 0, 22, 1);  chk("c_t6_valid", 64'(out_valid), 64'd1);
                               chk("c_t6_row",   64'(out_row),   64'd0);
        cyc(2'b00, 0, 0, 1);   chk("c_t7_row",   64'(out_row),   64'd1);
        cyc(2'b00, 0, 0, 1);   chk("c_t8_done",  64'(done),      64'd1);
        idle(2, 1);

        // --- 4: back-to-back matrices, B's first element on A's last handshake ---
        push(1'b0, 2, 1);
        push(1'b1, 4, 3);
        push(1'b0, 6, 5);
        push(1'b1, 8, 7);
        cyc(2'b01, 1, 0, 1);
        cyc(2'b11, 3, 2, 1);
        cyc(2'b10, 0, 4, 1);
        cyc(2'b01, 5, 0, 1);   chk("d_t3_row",   64'(out_row),   64'd1);
        cyc(2'b11, 7, 6, 1);   chk("d_t4_done",  64'(done),      64'd1);
        cyc(2'b10, 0, 8, 1);   chk("d_t5_data",  out_data, {32'd6, 32'd5});
        cyc(2'b00, 0, 0, 1);   chk("d_t6_data",  out_data, {32'd8, 32'd7});
        cyc(2'b00, 0, 0, 1);   chk("d_t7_done",  64'(done),      64'd1);
                               chk("d_overflow", 64'(overflow),  64'd0);
        idle(2, 1);

        // --- 5: overflow while a full matrix waits ---
        push(1'b0, 12, 11);
        push(1'b1, 14, 13);
        cyc(2'b01, 11, 0, 0);
        cyc(2'b11, 13, 12, 0);
        cyc(2'b10, 0, 14, 0);
        cyc(2'b01, 99, 0, 0);  chk("e_t3_ovf",   64'(overflow), 64'd0);
        cyc(2'b00, 0, 0, 0);   chk("e_t4_ovf",   64'(overflow), 64'd1);
                               chk("e_t4_data",  out_data, {32'd12, 32'd11});
        cyc(2'b00, 0, 0, 1);   chk("e_t5_ovf",   64'(overflow), 64'd1);
        cyc(2'b00, 0, 0, 1);   chk("e_t6_data",  out_data, {32'd14, 32'd13});
        cyc(2'b00, 0, 0, 1);   chk("e_t7_done",  64'(done),     64'd1);
                               chk("e_t7_ovf",   64'(overflow), 64'd1);
        idle(2, 1);

        // --- 6: reset with a partial matrix, then a fresh matrix ---
        push(1'b0, 32, 31);
        push(1'b1, 34, 33);
        cyc(2'b01, 21, 0, 1);
        rst_cyc();
        cyc(2'b01, 31, 0, 1);  chk("f_valid",    64'(out_valid), 64'd0);
                               chk("f_done",     64'(done),      64'd0);
                               chk("f_overflow", 64'(overflow),  64'd0);
        cyc(2'b11, 33, 32, 1);
        cyc(2'b10, 0, 34, 1);  chk("f_t2_valid", 64'(out_valid), 64'd1);
        cyc(2'b00, 0, 0, 1);
        cyc(2'b00, 0, 0, 1);   chk("f_done2",    64'(done),      64'd1);
        idle(3, 1);

        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
